// File: rtl/time_encode_if.sv
// Symbol-source handshake and time-memory write port of the time encoder.
// The slave modport is the encoder's view; master is the symbol source / memory side.
interface time_encode_if #(
    parameter int ADDR_W = 4
);
    logic [3:0]        sym_in;
    logic              sym_valid;
    logic              sym_ready;
    logic              clear_addr;
    logic              T_CEN;
    logic              T_WEN;
    logic [ADDR_W-1:0] T_A;
    logic [23:0]       T_D;
    logic              done;
    logic              err;
    logic [2:0]        err_pos;

    modport master (
        output sym_in, sym_valid, clear_addr,
        input  sym_ready, T_CEN, T_WEN, T_A, T_D, done, err, err_pos
    );

    modport slave (
        input  sym_in, sym_valid, clear_addr,
        output sym_ready, T_CEN, T_WEN, T_A, T_D, done, err, err_pos
    );
endinterface

// File: rtl/time_encode.sv
// Time encoder: validates an "HH:MM:SS" symbol stream, converts BCD pairs to binary
// and writes one packed {hour, min, sec} word into the time memory.
module time_encode #(
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    time_encode_if.slave       bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        REJECT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic              err_flag_q, err_flag_d;
    logic [2:0]        err_pos_q, err_pos_d;
    logic [3:0]        tens_q, tens_d;
    logic [7:0]        hour_q, hour_d;
    logic [7:0]        min_q, min_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sym_ready_q, sym_ready_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [23:0]       t_d_q, t_d_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [7:0]        tens_ext;
    logic [7:0]        value;
    logic              is_sep;
    logic              fail;
    logic              accept;

    // Per-symbol check; range limits apply to the combined value at the ones digit.
    always_comb begin
        tens_ext = {4'd0, tens_q};
        value    = (tens_ext << 3) + (tens_ext << 1) + {4'd0, bus.sym_in};
        is_sep   = (idx_q == 3'd2) || (idx_q == 3'd5);
        fail     = is_sep ? (bus.sym_in != 4'd10) : (bus.sym_in > 4'd9);
        if (!fail) begin
            if ((idx_q == 3'd1) && (value > 8'd23)) fail = 1'b1;
            if (((idx_q == 3'd4) || (idx_q == 3'd7)) && (value > 8'd59)) fail = 1'b1;
        end
    end

    assign accept = bus.sym_valid && sym_ready_q && (state_q == COLLECT);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_flag_d  = err_flag_q;
        err_pos_d   = err_pos_q;
        tens_d      = tens_q;
        hour_d      = hour_q;
        min_d       = min_q;
        ptr_d       = ptr_q;
        sym_ready_d = sym_ready_q;
        cen_d       = 1'b1;
        wen_d       = 1'b1;
        t_d_d       = t_d_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (bus.clear_addr) ptr_d = '0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if ((idx_q == 3'd0) || (idx_q == 3'd3) || (idx_q == 3'd6)) tens_d = bus.sym_in;
                    if (idx_q == 3'd1) hour_d = value;
                    if (idx_q == 3'd4) min_d = value;
                    // Only the first failure of a frame is reported.
                    if (fail && !err_flag_q) begin
                        err_flag_d = 1'b1;
                        err_pos_d  = idx_q;
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        sym_ready_d = 1'b0;
                        if (err_flag_q || fail) begin
                            state_d = REJECT;
                            err_d   = 1'b1;
                        end else begin
                            state_d = WRITE;
                            cen_d   = 1'b0;
                            wen_d   = 1'b0;
                            done_d  = 1'b1;
                            t_d_d   = {hour_q, min_q, value};
                        end
                    end
                end
            end
            WRITE: begin
                state_d     = COLLECT;
                sym_ready_d = 1'b1;
                if (!bus.clear_addr) ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            REJECT: begin
                state_d     = COLLECT;
                sym_ready_d = 1'b1;
                err_flag_d  = 1'b0;
            end
            default: begin
                state_d     = COLLECT;
                sym_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            err_flag_q  <= 1'b0;
            err_pos_q   <= 3'd0;
            tens_q      <= 4'd0;
            hour_q      <= 8'd0;
            min_q       <= 8'd0;
            ptr_q       <= '0;
            sym_ready_q <= 1'b1;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            t_d_q       <= 24'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_flag_q  <= err_flag_d;
            err_pos_q   <= err_pos_d;
            tens_q      <= tens_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            ptr_q       <= ptr_d;
            sym_ready_q <= sym_ready_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            t_d_q       <= t_d_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.T_CEN     = cen_q;
    assign bus.T_WEN     = wen_q;
    assign bus.T_A       = ptr_q;
    assign bus.T_D       = t_d_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_pos   = err_pos_q;

endmodule

// File: tb/tb_time_encode.sv
// Bench for time_encode: a frame model pushes expected writes/rejects to a queue,
// a negedge monitor pops and compares them; scenario tasks add their own inline checks.
module tb_time_encode;

    localparam int ADDR_W = 4;
    localparam int P      = 10;

    typedef logic [7:0][3:0] frame_t;

    typedef struct {
        logic              is_err;
        logic [2:0]        pos;
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #(P/2) clk = ~clk;

    time_encode_if #(.ADDR_W(ADDR_W)) bus ();

    time_encode #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t              sb_q[$];
    exp_t              mon_e;
    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] exp_ptr = '0;
    bit                mon_en = 1'b0;
    bit                track_en = 1'b0;
    time               low_q[$];

    function automatic frame_t mk(input int s0, input int s1, input int s2, input int s3,
                                  input int s4, input int s5, input int s6, input int s7);
        frame_t f;
        f[0] = 4'(s0); f[1] = 4'(s1); f[2] = 4'(s2); f[3] = 4'(s3);
        f[4] = 4'(s4); f[5] = 4'(s5); f[6] = 4'(s6); f[7] = 4'(s7);
        return f;
    endfunction

    // Reference frame model: first failing index wins, range checked on the ones digit.
    function automatic exp_t model(input frame_t f, input logic [ADDR_W-1:0] addr);
        exp_t e;
        int   h, m, s;
        bit   bad;
        bit   fl;
        h = 10 * int'(f[0]) + int'(f[1]);
        m = 10 * int'(f[3]) + int'(f[4]);
        s = 10 * int'(f[6]) + int'(f[7]);
        bad   = 1'b0;
        e.pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) fl = (f[i] != 4'd10);
            else                  fl = (f[i] > 4'd9);
            if (!fl && i == 1 && h > 23) fl = 1'b1;
            if (!fl && i == 4 && m > 59) fl = 1'b1;
            if (!fl && i == 7 && s > 59) fl = 1'b1;
            if (fl && !bad) begin
                bad   = 1'b1;
                e.pos = 3'(i);
            end
        end
        e.is_err = bad;
        e.addr   = addr;
        e.data   = {8'(h), 8'(m), 8'(s)};
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: done=%b err=%b T_A=%0d T_D=%h, no result expected",
                             bus.done, bus.err, bus.T_A, bus.T_D);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_err) begin
                        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.err_pos !== mon_e.pos ||
                            bus.T_CEN !== 1'b1 || bus.T_WEN !== 1'b1 || bus.sym_ready !== 1'b0) begin
                            errors++;
                            $display("[TB] FAIL reject_result: got err=%b done=%b pos=%0d cen=%b wen=%b rdy=%b, want err=1 done=0 pos=%0d cen=1 wen=1 rdy=0",
                                     bus.err, bus.done, bus.err_pos, bus.T_CEN, bus.T_WEN, bus.sym_ready, mon_e.pos);
                        end
                    end else begin
                        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.T_CEN !== 1'b0 || bus.T_WEN !== 1'b0 ||
                            bus.T_A !== mon_e.addr || bus.T_D !== mon_e.data || bus.sym_ready !== 1'b0) begin
                            errors++;
                            $display("[TB] FAIL write_result: got done=%b err=%b cen=%b wen=%b A=%0d D=%h rdy=%b, want done=1 err=0 cen=0 wen=0 A=%0d D=%h rdy=0",
                                     bus.done, bus.err, bus.T_CEN, bus.T_WEN, bus.T_A, bus.T_D, bus.sym_ready,
                                     mon_e.addr, mon_e.data);
                        end
                    end
                end
            end else if (bus.T_CEN !== 1'b1 || bus.T_WEN !== 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL stray_write: got cen=%b wen=%b without done, want cen=1 wen=1",
                         bus.T_CEN, bus.T_WEN);
            end
        end
    end

    always @(negedge clk) begin
        if (track_en && bus.sym_ready !== 1'b1) low_q.push_back($time);
    end

    initial begin
        #(200000);
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        reset          = 1'b1;
        bus.sym_valid  = 1'b0;
        bus.clear_addr = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_ptr = '0;
    endtask

    task automatic drive_sym(input logic [3:0] s);
        int n;
        bus.sym_valid = 1'b1;
        bus.sym_in    = s;
        n = 0;
        while (bus.sym_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: sym_ready=%b after %0d cycles, want 1", bus.sym_ready, n);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f, input bit keep_valid);
        exp_t e;
        e = model(f, exp_ptr);
        sb_q.push_back(e);
        if (!e.is_err) exp_ptr = exp_ptr + 1'b1;
        for (int i = 0; i < 8; i++) drive_sym(f[i]);
        if (!keep_valid) bus.sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.sym_valid  = 1'b0;
        bus.sym_in     = 4'd0;
        bus.clear_addr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.sym_ready, bus.T_CEN, bus.T_WEN, bus.T_A, bus.T_D, bus.done, bus.err, bus.err_pos} !==
            {1'b1, 1'b1, 1'b1, 4'd0, 24'd0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got rdy=%b cen=%b wen=%b A=%0d D=%h done=%b err=%b pos=%0d, want 1 1 1 0 000000 0 0 0",
                     bus.sym_ready, bus.T_CEN, bus.T_WEN, bus.T_A, bus.T_D, bus.done, bus.err, bus.err_pos);
        end
        reset   = 1'b0;
        exp_ptr = '0;
        mon_en  = 1'b1;
    endtask

    task automatic test_basic_write();
        send_frame(mk(1, 2, 10, 3, 4, 10, 5, 6), 1'b0);
        checks++;
        if ({bus.T_CEN, bus.T_WEN, bus.T_A, bus.T_D, bus.done, bus.sym_ready} !==
            {1'b0, 1'b0, 4'd0, 24'h0C2238, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_write: got cen=%b wen=%b A=%0d D=%h done=%b rdy=%b, want 0 0 0 0c2238 1 0",
                     bus.T_CEN, bus.T_WEN, bus.T_A, bus.T_D, bus.done, bus.sym_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.T_A, bus.T_CEN, bus.T_WEN, bus.done, bus.sym_ready, bus.T_D} !==
            {4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0C2238}) begin
            errors++;
            $display("[TB] FAIL basic_after: got A=%0d cen=%b wen=%b done=%b rdy=%b D=%h, want 1 1 1 0 1 0c2238",
                     bus.T_A, bus.T_CEN, bus.T_WEN, bus.done, bus.sym_ready, bus.T_D);
        end
    endtask

    task automatic test_reject();
        send_frame(mk(2, 4, 10, 0, 0, 10, 0, 0), 1'b0);
        checks++;
        if ({bus.err, bus.err_pos, bus.T_CEN, bus.T_WEN, bus.T_A, bus.sym_ready} !==
            {1'b1, 3'd1, 1'b1, 1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reject_hour: got err=%b pos=%0d cen=%b wen=%b A=%0d rdy=%b, want 1 1 1 1 1 0",
                     bus.err, bus.err_pos, bus.T_CEN, bus.T_WEN, bus.T_A, bus.sym_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.err, bus.T_A, bus.sym_ready, bus.T_D} !== {1'b0, 4'd1, 1'b1, 24'h0C2238}) begin
            errors++;
            $display("[TB] FAIL reject_after: got err=%b A=%0d rdy=%b D=%h, want 0 1 1 0c2238",
                     bus.err, bus.T_A, bus.sym_ready, bus.T_D);
        end
        send_frame(mk(2, 3, 10, 5, 9, 10, 5, 9), 1'b0);
        checks++;
        if ({bus.done, bus.T_A, bus.T_D} !== {1'b1, 4'd1, 24'h173B3B}) begin
            errors++;
            $display("[TB] FAIL max_time_write: got done=%b A=%0d D=%h, want 1 1 173b3b",
                     bus.done, bus.T_A, bus.T_D);
        end
    endtask

    task automatic test_first_error();
        send_frame(mk(0, 0, 11, 6, 0, 10, 7, 7), 1'b0);
        checks++;
        if ({bus.err, bus.err_pos} !== {1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL first_error_kept: got err=%b pos=%0d, want err=1 pos=2", bus.err, bus.err_pos);
        end
        send_frame(mk(0, 0, 10, 0, 0, 10, 6, 0), 1'b0);
        checks++;
        if ({bus.err, bus.err_pos} !== {1'b1, 3'd7}) begin
            errors++;
            $display("[TB] FAIL second_range: got err=%b pos=%0d, want err=1 pos=7", bus.err, bus.err_pos);
        end
        send_frame(mk(0, 9, 10, 6, 0, 10, 0, 0), 1'b0);
        checks++;
        if ({bus.err, bus.err_pos, bus.T_A} !== {1'b1, 3'd4, 4'd2}) begin
            errors++;
            $display("[TB] FAIL minute_range: got err=%b pos=%0d A=%0d, want err=1 pos=4 A=2",
                     bus.err, bus.err_pos, bus.T_A);
        end
    endtask

    task automatic test_wrap_and_clear();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send_frame(mk(k / 10, k % 10, 10, 1, k % 6, 10, 2, k % 10), 1'b0);
        end
        checks++;
        if ({bus.done, bus.T_A} !== {1'b1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_write: got done=%b A=%0d, want done=1 A=0", bus.done, bus.T_A);
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_frame(mk(1, k, 10, 4, k, 10, 3, k), 1'b0);
            if (k == 2) begin
                bus.clear_addr = 1'b1;
                checks++;
                if ({bus.done, bus.T_A} !== {1'b1, 4'd2}) begin
                    errors++;
                    $display("[TB] FAIL clear_during_write: got done=%b A=%0d, want done=1 A=2", bus.done, bus.T_A);
                end
                @(negedge clk);
                bus.clear_addr = 1'b0;
                exp_ptr = '0;
                checks++;
                if (bus.T_A !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL clear_result: got A=%0d, want 0", bus.T_A);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 5; i++) drive_sym(4'(i == 2 ? 10 : i + 1));
        do_reset();
        checks++;
        if ({bus.sym_ready, bus.T_A, bus.done, bus.err} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got rdy=%b A=%0d done=%b err=%b, want 1 0 0 0",
                     bus.sym_ready, bus.T_A, bus.done, bus.err);
        end
        send_frame(mk(0, 0, 10, 0, 0, 10, 0, 1), 1'b0);
        checks++;
        if ({bus.done, bus.T_A, bus.T_D} !== {1'b1, 4'd0, 24'h000001}) begin
            errors++;
            $display("[TB] FAIL after_reset_write: got done=%b A=%0d D=%h, want 1 0 000001",
                     bus.done, bus.T_A, bus.T_D);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        @(negedge clk);
        low_q.delete();
        t0 = $time;
        track_en = 1'b1;
        send_frame(mk(0, 1, 10, 0, 2, 10, 0, 3), 1'b1);
        send_frame(mk(1, 1, 10, 2, 2, 10, 3, 3), 1'b1);
        send_frame(mk(2, 0, 10, 4, 5, 10, 5, 8), 1'b0);
        @(negedge clk);
        track_en = 1'b0;
        checks++;
        if (low_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL ready_low_count: got %0d not-ready cycles, want 3", low_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (low_q[i] != t0 + time'((9 * i + 8) * P)) begin
                    errors++;
                    $display("[TB] FAIL ready_low_slot%0d: got t=%0t, want t=%0t",
                             i, low_q[i], t0 + time'((9 * i + 8) * P));
                end
            end
        end
    endtask

    initial begin
        $display("[TB] time_encode bench start");
        test_reset();
        test_basic_write();
        test_reject();
        test_first_error();
        test_wrap_and_clear();
        test_midframe_reset();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d outstanding results, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
